axi_lite_cmd_master: RTL
========================

AXI_LITE_CMD_MASTER -- requirements
Module: axi_lite_cmd_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, the abort threshold in clocks (used only with REQ-042).
REQ-002 clk_i  input  1  clock; all logic on rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 cmd_valid_i  input  1  command offered.
REQ-005 cmd_ready_o  output  1  command accepted when high with cmd_valid_i.
REQ-006 cmd_we_i  input  1  1=write, 0=read.
REQ-007 cmd_addr_i  input  32  byte address.
REQ-008 cmd_wdata_i  input  32  write data.
REQ-009 cmd_strb_i  input  4  byte strobes.
REQ-010 rsp_valid_o  output  1  one-cycle completion pulse.
REQ-011 rsp_rdata_o  output  32  read data; 0 for writes.
REQ-012 rsp_resp_o  output  2  AXI response code.
REQ-013 m_awaddr_o  output  32  AW address.
REQ-014 m_awvalid_o  output  1  AW valid.
REQ-015 m_awready_i  input  1  AW ready.
REQ-016 m_wdata_o  output  32  W data.
REQ-017 m_wstrb_o  output  4  W strobes.
REQ-018 m_wvalid_o  output  1  W valid.
REQ-019 m_wready_i  input  1  W ready.
REQ-020 m_bresp_i  input  2  B response.
REQ-021 m_bvalid_i  input  1  B valid.
REQ-022 m_bready_o  output  1  B ready.
REQ-023 m_araddr_o  output  32  AR address.
REQ-024 m_arvalid_o  output  1  AR valid.
REQ-025 m_arready_i  input  1  AR ready.
REQ-026 m_rdata_i  input  32  R data.
REQ-027 m_rresp_i  input  2  R response.
REQ-028 m_rvalid_i  input  1  R valid.
REQ-029 m_rready_o  output  1  R ready.

Function
REQ-030 States SHALL be IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE; cmd_ready_o=1 only in IDLE; accept registers addr/wdata/strb/we and goes to WR_REQ (we=1) or RD_REQ.
REQ-031 WR_REQ: m_awvalid_o and m_wvalid_o SHALL both be 1 in the first WR_REQ cycle; each SHALL drop independently on its own handshake, in either order or simultaneously; WR_RESP is entered once both have completed.
REQ-032 WR_RESP: m_bready_o=1; B handshake captures bresp and goes to DONE; rsp_rdata_o=0.
REQ-033 RD_REQ: m_arvalid_o=1 until AR handshake, then RD_RESP with m_rready_o=1; R handshake captures rdata/rresp and goes to DONE.
REQ-034 DONE: rsp_valid_o=1 for exactly one cycle, then IDLE; rsp_rdata_o/rsp_resp_o hold until the next DONE.
REQ-035 Once asserted, any AXI valid with its addr/data/strb SHALL stay stable until handshake (except REQ-042).
REQ-036 m_bvalid_i/m_rvalid_i outside their wait state SHALL be ignored (ready low).
REQ-037 Latency with an always-ready slave responding the cycle after handshake: accept at cycle 0, AW/W/AR at 1, B/R at 2, rsp_valid_o at 3, cmd_ready_o at 4.
REQ-038 Strobe 4'h0 and any address SHALL be forwarded unchanged; no alignment check.

Reset
REQ-039 rst_ni low SHALL immediately force state IDLE, all outputs 0 (cmd_ready_o included), and abandon any in-flight transaction with no response pulse.
REQ-040 cmd_ready_o SHALL be 1 in the first cycle after rst_ni rises.

Configuration
REQ-041 Without macro AXI_LITE_CMD_MASTER_TIMEOUT_EN, the block SHALL wait indefinitely in any state, and TIMEOUT_CYCLES has no effect.
REQ-042 With it defined, a counter cleared on leaving IDLE reaching TIMEOUT_CYCLES SHALL drop all AXI valids/readies and go to DONE with rsp_resp_o=2'b10, rsp_rdata_o=0.

Verification
REQ-043 Write 0x14/0x61626380/strb F, slave ready, bresp 00 -> AW/W valid cycle 1, rsp_valid_o cycle 3, resp 00.
REQ-044 Write, awready delayed 3 cycles, wready immediate -> wvalid high 1 cycle, awvalid 4 cycles with awaddr stable, exactly one rsp.
REQ-045 Read 0x04, rvalid 2 cycles after AR, rdata 0x00000005 -> rsp_rdata_o=0x00000005, resp 00.
REQ-046 cmd_valid_i held during busy -> no second accept until the cycle after rsp_valid_o.
REQ-047 rst_ni low in WR_RESP -> all outputs 0 asynchronously, no rsp_valid_o.
REQ-048 TIMEOUT_EN, TIMEOUT_CYCLES=16, bvalid never -> rsp_valid_o with resp 10 after 16 cycles; in the no-macro build, no response ever.

Source files
------------

// File: rtl/axi_lite_cmd_master_if.sv
// AXI4-Lite master-side bus bundle used by axi_lite_cmd_master.
// Signal names keep the _o/_i sense as seen from the master.
interface axi_lite_cmd_master_if;
    logic [31:0] m_awaddr_o;
    logic        m_awvalid_o;
    logic        m_awready_i;
    logic [31:0] m_wdata_o;
    logic [3:0]  m_wstrb_o;
    logic        m_wvalid_o;
    logic        m_wready_i;
    logic [1:0]  m_bresp_i;
    logic        m_bvalid_i;
    logic        m_bready_o;
    logic [31:0] m_araddr_o;
    logic        m_arvalid_o;
    logic        m_arready_i;
    logic [31:0] m_rdata_i;
    logic [1:0]  m_rresp_i;
    logic        m_rvalid_i;
    logic        m_rready_o;

    modport master (
        output m_awaddr_o, m_awvalid_o,
        input  m_awready_i,
        output m_wdata_o, m_wstrb_o, m_wvalid_o,
        input  m_wready_i,
        input  m_bresp_i, m_bvalid_i,
        output m_bready_o,
        output m_araddr_o, m_arvalid_o,
        input  m_arready_i,
        input  m_rdata_i, m_rresp_i, m_rvalid_i,
        output m_rready_o
    );

    modport slave (
        input  m_awaddr_o, m_awvalid_o,
        output m_awready_i,
        input  m_wdata_o, m_wstrb_o, m_wvalid_o,
        output m_wready_i,
        output m_bresp_i, m_bvalid_i,
        input  m_bready_o,
        input  m_araddr_o, m_arvalid_o,
        output m_arready_i,
        output m_rdata_i, m_rresp_i, m_rvalid_i,
        input  m_rready_o
    );
endinterface

// File: rtl/axi_lite_cmd_master.sv
// Single-command AXI4-Lite master: one read or write in flight, one-cycle response pulse.
// Define AXI_LITE_CMD_MASTER_TIMEOUT_EN to enable the TIMEOUT_CYCLES abort watchdog.
module axi_lite_cmd_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_addr_i,
    input  logic [31:0] cmd_wdata_i,
    input  logic [3:0]  cmd_strb_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic [1:0]  rsp_resp_o,
    axi_lite_cmd_master_if.master axi
);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        DONE
    } state_e;

    state_e      state_q;
    state_e      state_d;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  strb_q;
    logic        aw_done_q;
    logic        w_done_q;
    logic [31:0] rdata_q;
    logic [1:0]  resp_q;

    logic accept;
    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic ar_hs;
    logic r_hs;
    logic timeout_hit;
    logic abort;

    if (TIMEOUT_CYCLES == 0) begin : g_timeout_check
        $error("axi_lite_cmd_master: TIMEOUT_CYCLES must be at least 1");
    end

    // Ready is masked by reset so every output reads 0 while rst_ni is low.
    assign cmd_ready_o = rst_ni && (state_q == IDLE);
    assign accept      = cmd_valid_i && cmd_ready_o;

    assign aw_hs = axi.m_awvalid_o && axi.m_awready_i;
    assign w_hs  = axi.m_wvalid_o  && axi.m_wready_i;
    assign b_hs  = axi.m_bvalid_i  && axi.m_bready_o;
    assign ar_hs = axi.m_arvalid_o && axi.m_arready_i;
    assign r_hs  = axi.m_rvalid_i  && axi.m_rready_o;

    assign axi.m_awaddr_o  = addr_q;
    assign axi.m_awvalid_o = (state_q == WR_REQ) && !aw_done_q;
    assign axi.m_wdata_o   = wdata_q;
    assign axi.m_wstrb_o   = strb_q;
    assign axi.m_wvalid_o  = (state_q == WR_REQ) && !w_done_q;
    assign axi.m_bready_o  = (state_q == WR_RESP);
    assign axi.m_araddr_o  = addr_q;
    assign axi.m_arvalid_o = (state_q == RD_REQ);
    assign axi.m_rready_o  = (state_q == RD_RESP);

    assign rsp_valid_o = (state_q == DONE);
    assign rsp_rdata_o = rdata_q;
    assign rsp_resp_o  = resp_q;

`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_cnt_q;
    logic             busy;

    assign busy        = state_q inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP};
    assign timeout_hit = busy && (tmo_cnt_q == CNT_LAST);

    // Counts busy cycles; the TIMEOUT_CYCLES-th busy cycle triggers the abort.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt_q <= '0;
        end else if (!busy) begin
            tmo_cnt_q <= '0;
        end else if (!timeout_hit) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A genuine completion in the same cycle as the watchdog wins over the abort.
    always_comb begin
        state_d = state_q;
        abort   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = cmd_we_i ? WR_REQ : RD_REQ;
                end
            end
            WR_REQ: begin
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (b_hs) begin
                    state_d = DONE;
                end
            end
            RD_REQ: begin
                if (ar_hs) begin
                    state_d = RD_RESP;
                end
            end
            RD_RESP: begin
                if (r_hs) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (timeout_hit && (state_d != DONE)) begin
            state_d = DONE;
            abort   = 1'b1;
        end
    end

    // AW and W complete independently; each done flag lives only while in WR_REQ.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= '0;
        end else begin
            if (accept) begin
                addr_q  <= cmd_addr_i;
                wdata_q <= cmd_wdata_i;
                strb_q  <= cmd_strb_i;
            end
            if ((state_q == WR_REQ) && (state_d == WR_REQ)) begin
                if (aw_hs) begin
                    aw_done_q <= 1'b1;
                end
                if (w_hs) begin
                    w_done_q <= 1'b1;
                end
            end else begin
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end
            if (abort) begin
                rdata_q <= '0;
                resp_q  <= 2'b10;
            end else if (b_hs) begin
                rdata_q <= '0;
                resp_q  <= axi.m_bresp_i;
            end else if (r_hs) begin
                rdata_q <= axi.m_rdata_i;
                resp_q  <= axi.m_rresp_i;
            end
        end
    end

endmodule
